// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, axis total helper and 12-bit coordinate type
package vga_pkg;

    localparam int COORD_W   = 12;
    localparam int COORD_MAX = 4095;

    localparam int H_ACTIVE_DEF = 1280;
    localparam int H_FP_DEF     = 48;
    localparam int H_SYNC_DEF   = 112;
    localparam int H_BP_DEF     = 248;

    localparam int V_ACTIVE_DEF = 1024;
    localparam int V_FP_DEF     = 1;
    localparam int V_SYNC_DEF   = 3;
    localparam int V_BP_DEF     = 38;

    typedef logic [COORD_W-1:0] coord_t;

    // Total period of one scan axis (visible + front porch + sync + back porch).
    function automatic int axis_total(input int act, input int fp, input int sy, input int bp);
        return act + fp + sy + bp;
    endfunction

    localparam int HT_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int VT_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one scan axis: position counter, wrap, sync and active decode
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int   ACTIVE   = H_ACTIVE_DEF,
    parameter int   FP       = H_FP_DEF,
    parameter int   SYNC     = H_SYNC_DEF,
    parameter int   BP       = H_BP_DEF,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [COORD_W-1:0] pos,
    output logic               sync,
    output logic               act_next,
    output logic               carry
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    generate
        if (TOTAL > COORD_MAX) begin : g_total_too_large
            $error("vga_axis_counter: axis total %0d exceeds 12-bit range", TOTAL);
        end
    endgenerate

    localparam coord_t LAST       = coord_t'(TOTAL - 1);
    localparam coord_t ACT_END    = coord_t'(ACTIVE);
    localparam coord_t SYNC_START = coord_t'(ACTIVE + FP);
    localparam coord_t SYNC_END   = coord_t'(ACTIVE + FP + SYNC);

    // cnt is the position that will be presented on pos at the next edge;
    // decoding it one cycle early keeps every registered output aligned.
    coord_t cnt;
    logic   sync_next;

    assign act_next  = (cnt < ACT_END);
    assign carry     = en && (cnt == LAST);
    assign sync_next = ((cnt >= SYNC_START) && (cnt < SYNC_END)) ? SYNC_POL : ~SYNC_POL;

    // Advance the axis position when enabled and register the decoded position and sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            pos  <= '0;
            sync <= ~SYNC_POL;
        end else begin
            pos  <= cnt;
            sync <= sync_next;
            if (en) begin
                cnt <= (cnt == LAST) ? '0 : cnt + coord_t'(1);
            end
        end
    end

endmodule

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - VGA scan generator with per-frame sample hold; VGA_SCAN_PEAK_HOLD_EN selects peak hold
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  sample_in,
    input  logic        sample_valid,
    output logic [11:0] horz,
    output logic [11:0] vert,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic        frame_start,
    output logic [9:0]  sample
);

    logic       h_act_next;
    logic       h_carry;
    logic       v_act_next;
    logic       v_carry;
    logic       wrap_q;
    logic [9:0] acc;
    logic [9:0] acc_in;

    vga_axis_counter #(
        .ACTIVE   (H_ACTIVE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .SYNC_POL (SYNC_POL)
    ) u_horz (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (1'b1),
        .pos      (horz),
        .sync     (hsync),
        .act_next (h_act_next),
        .carry    (h_carry)
    );

    vga_axis_counter #(
        .ACTIVE   (V_ACTIVE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_vert (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (h_carry),
        .pos      (vert),
        .sync     (vsync),
        .act_next (v_act_next),
        .carry    (v_carry)
    );

    // Fold the current input into the running frame value (peak or last sample).
    always_comb begin
        acc_in = acc;
        if (sample_valid) begin
`ifdef VGA_SCAN_PEAK_HOLD_EN
            acc_in = (sample_in > acc) ? sample_in : acc;
`else
            acc_in = sample_in;
`endif
        end
    end

    // wrap_q marks that both counters now sit at 0/0; it resets high so the
    // first edge after reset presents a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q      <= 1'b1;
            active      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            wrap_q      <= h_carry && v_carry;
            active      <= h_act_next && v_act_next;
            frame_start <= wrap_q;
        end
    end

    // Publish the finished frame's value as frame_start rises; inputs taken
    // during the frame_start cycle itself land in the freshly cleared acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            sample <= '0;
        end else if (wrap_q) begin
            sample <= acc_in;
            acc    <= '0;
        end else begin
            acc    <= acc_in;
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - self-checking bench for vga_scan_gen on a reduced timing set
module tb_vga_scan_gen;

    localparam int HA = 16;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 6;
    localparam int VA = 8;
    localparam int VF = 1;
    localparam int VS = 3;
    localparam int VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

`ifdef VGA_SCAN_PEAK_HOLD_EN
    localparam bit PEAK = 1'b1;
`else
    localparam bit PEAK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  sample_in = '0;
    logic        sample_valid = 1'b0;
    logic [11:0] horz;
    logic [11:0] vert;
    logic        hsync;
    logic        vsync;
    logic        active;
    logic        frame_start;
    logic [9:0]  sample;

    int total = 0;
    int bad = 0;
    int m_h;
    int m_v;
    int tb_acc;
    int cur_sample;
    int sb[$];

    int fs_count;
    int fs_h;
    int fs_v;
    int act_count;
    int hs_count;
    int hs_first;
    int vs_count;
    int vs_first;

    always #5 clk = ~clk;

    vga_scan_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .horz         (horz),
        .vert         (vert),
        .hsync        (hsync),
        .vsync        (vsync),
        .active       (active),
        .frame_start  (frame_start),
        .sample       (sample)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_horz", horz, 0);
        check("rst_vert", vert, 0);
        check("rst_active", active, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_hsync", hsync, 0);
        check("rst_vsync", vsync, 0);
        check("rst_sample", sample, 0);
    endtask

    task automatic model_restart();
        m_h = HT - 1;
        m_v = VT - 1;
        tb_acc = 0;
        cur_sample = 0;
        sb.delete();
    endtask

    // One pixel clock: account for the driven input, then compare the DUT against the model.
    task automatic tick();
        if (sample_valid) begin
            if (PEAK) tb_acc = (int'(sample_in) > tb_acc) ? int'(sample_in) : tb_acc;
            else      tb_acc = int'(sample_in);
        end
        if (m_h == HT - 1 && m_v == VT - 1) begin
            sb.push_back(tb_acc);
            tb_acc = 0;
        end
        @(posedge clk);
        #1;
        m_h++;
        if (m_h == HT) begin
            m_h = 0;
            m_v++;
            if (m_v == VT) m_v = 0;
        end
        check("horz", horz, m_h);
        check("vert", vert, m_v);
        check("hsync", hsync, (m_h >= HA + HF && m_h < HA + HF + HS) ? 1 : 0);
        check("vsync", vsync, (m_v >= VA + VF && m_v < VA + VF + VS) ? 1 : 0);
        check("active", active, (m_h < HA && m_v < VA) ? 1 : 0);
        check("frame_start", frame_start, (m_h == 0 && m_v == 0) ? 1 : 0);
        if (m_h == 0 && m_v == 0) begin
            if (sb.size() == 0) check("scoreboard_empty", 1, 0);
            else cur_sample = sb.pop_front();
        end
        check("sample", sample, cur_sample);
    endtask

    task automatic run_to(input int h, input int v);
        bit hit = 1'b0;
        for (int n = 0; n < HT * VT + 2; n++) begin
            tick();
            if (m_h == h && m_v == v) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) check("run_to_timeout", 0, 1);
    endtask

    task automatic drive_sample(input int value);
        sample_in = 10'(value);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    initial begin
        model_restart();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;

        // Full first frame: scan sequence, sync widths, single frame_start, active area.
        fs_count = 0; fs_h = -1; fs_v = -1; act_count = 0;
        hs_count = 0; hs_first = -1; vs_count = 0; vs_first = -1;
        for (int i = 0; i < HT * VT; i++) begin
            tick();
            if (frame_start) begin
                fs_count++;
                fs_h = int'(horz);
                fs_v = int'(vert);
            end
            if (active) act_count++;
            if (vert == 0 && hsync) begin
                if (hs_first < 0) hs_first = int'(horz);
                hs_count++;
            end
            if (vsync) begin
                if (vs_first < 0) vs_first = int'(vert);
                vs_count++;
            end
        end
        check("frame_start_count", fs_count, 1);
        check("frame_start_horz", fs_h, 0);
        check("frame_start_vert", fs_v, 0);
        check("active_cycles", act_count, HA * VA);
        check("hsync_width", hs_count, HS);
        check("hsync_first_col", hs_first, HA + HF);
        check("vsync_cycles", vs_count, VS * HT);
        check("vsync_first_row", vs_first, VA + VF);

        // Frame N: feed 100, 700, 300; frame N+1 carries none.
        tick();
        run_to(3, 1);
        drive_sample(100);
        run_to(5, 2);
        drive_sample(700);
        run_to(7, 6);
        drive_sample(300);
        run_to(0, 0);
        check("published_after_three", sample, PEAK ? 700 : 300);
        run_to(10, 4);
        check("held_mid_frame", sample, PEAK ? 700 : 300);
        run_to(0, 0);
        check("published_empty_frame", sample, 0);

        // Sample on the frame_start cycle belongs to the new frame.
        drive_sample(900);
        check("frame_start_sample_excluded", sample, 0);
        run_to(0, 0);
        check("frame_start_sample_next", sample, 900);

        // Sample on the last cycle of a frame belongs to the outgoing frame.
        run_to(HT - 1, VT - 1);
        drive_sample(50);
        check("last_cycle_publish", sample, 50);

        // Mid-frame reset discards the partial frame.
        run_to(2, 3);
        drive_sample(600);
        run_to(10, 5);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        model_restart();
        tick();
        check("post_reset_horz", horz, 0);
        check("post_reset_vert", vert, 0);
        check("post_reset_frame_start", frame_start, 1);
        check("post_reset_active", active, 1);
        check("post_reset_sample", sample, 0);
        run_to(0, 0);
        check("post_reset_next_frame", sample, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
